// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with a valid/ready DIRECT mode and a
// self-stepping SCAN mode for multiplexed display digits and rows.
module decoder_scan_nto2n #(
    parameter int unsigned N          = 3,
    parameter int unsigned SCAN_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      a,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int unsigned W  = 2**N;
    localparam int unsigned DW = $clog2(SCAN_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sel_q, sel_d;      // active-high one-hot; polarity applied at the port
    logic            y_valid_q, y_valid_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [DW-1:0]   div_q, div_d;
    logic [N-1:0]    idx_inc;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] k);
        onehot = W'(1) << k;
    endfunction

    assign in_ready = (state_q == DIRECT) && en && !mode;
    assign idx_inc  = idx_q + N'(1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        y_valid_d = y_valid_q;
        idx_d     = idx_q;
        wrap_d    = 1'b0;
        div_d     = div_q;

        if (!en) begin
            state_d   = IDLE;
            sel_d     = '0;
            y_valid_d = 1'b0;
            idx_d     = '0;
            div_d     = '0;
        end else begin
            unique case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        // Scan entry starts at position 0 without a wrap pulse.
                        state_d   = SCAN;
                        idx_d     = '0;
                        div_d     = '0;
                        sel_d     = onehot('0);
                        y_valid_d = 1'b1;
                    end else if (state_q == IDLE) begin
                        state_d   = DIRECT;
                        sel_d     = '0;
                        y_valid_d = 1'b0;
                    end else if (in_valid) begin
                        sel_d     = onehot(a);
                        y_valid_d = 1'b1;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_d   = DIRECT;
                        sel_d     = '0;
                        y_valid_d = 1'b0;
                        idx_d     = '0;
                        div_d     = '0;
                    end else if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        idx_d  = idx_inc;
                        sel_d  = onehot(idx_inc);
                        wrap_d = (idx_inc == '0);
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            y_valid_q <= 1'b0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
            wrap_q    <= wrap_d;
            div_q     <= div_d;
        end
    end

    assign y       = ACTIVE_LOW ? ~sel_q : sel_q;
    assign y_valid = y_valid_q;
    assign idx     = idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Self-checking bench: two decoder instances (active-high/SCAN_DIV=2 and
// active-low/SCAN_DIV=1) share stimulus and are compared against a timeline model.
module tb_decoder_scan_nto2n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] a = '0;
    logic       in_valid = 1'b0;

    logic       in_ready0, y_valid0, wrap0;
    logic [7:0] y0;
    logic [2:0] idx0;
    logic       in_ready1, y_valid1, wrap1;
    logic [7:0] y1;
    logic [2:0] idx1;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: current mode, cycles since scan entry, last accepted code (-1 = none).
    int m_st   = 0;   // 0 idle, 1 direct, 2 scan
    int m_t    = 0;
    int m_code = -1;

    always #5 clk = ~clk;

    decoder_scan_nto2n #(.N(3), .SCAN_DIV(2), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .in_valid(in_valid),
        .in_ready(in_ready0), .y(y0), .y_valid(y_valid0), .idx(idx0), .wrap(wrap0)
    );

    decoder_scan_nto2n #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .in_valid(in_valid),
        .in_ready(in_ready1), .y(y1), .y_valid(y_valid1), .idx(idx1), .wrap(wrap1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic expect_inst(input int div, input bit al, output logic [7:0] ey,
                               output logic ev, output logic [2:0] ei, output logic ew);
        int p;
        ey = 8'h00; ev = 1'b0; ei = 3'd0; ew = 1'b0;
        if (m_st == 1 && m_code >= 0) begin
            ey = 8'(1 << m_code);
            ev = 1'b1;
        end else if (m_st == 2) begin
            p  = (m_t / div) % 8;
            ei = 3'(p);
            ey = 8'(1 << p);
            ev = 1'b1;
            ew = (m_t > 0) && (m_t % (div * 8) == 0);
        end
        if (al) ey = ~ey;
    endtask

    task automatic check_outputs();
        logic [7:0] ey;
        logic       ev, ew;
        logic [2:0] ei;
        expect_inst(2, 1'b0, ey, ev, ei, ew);
        check("hi.y", 32'(y0), 32'(ey));
        check("hi.y_valid", 32'(y_valid0), 32'(ev));
        check("hi.idx", 32'(idx0), 32'(ei));
        check("hi.wrap", 32'(wrap0), 32'(ew));
        expect_inst(1, 1'b1, ey, ev, ei, ew);
        check("lo.y", 32'(y1), 32'(ey));
        check("lo.y_valid", 32'(y_valid1), 32'(ev));
        check("lo.idx", 32'(idx1), 32'(ei));
        check("lo.wrap", 32'(wrap1), 32'(ew));
    endtask

    task automatic model_step();
        if (reset) begin
            m_st = 0; m_t = 0; m_code = -1;
        end else if (!en) begin
            m_st = 0; m_t = 0; m_code = -1;
        end else if (m_st == 0) begin
            if (mode) begin m_st = 2; m_t = 0; end
            else begin m_st = 1; m_code = -1; end
        end else if (m_st == 1) begin
            if (mode) begin m_st = 2; m_t = 0; end
            else if (in_valid) m_code = int'(a);
        end else begin
            if (!mode) begin m_st = 1; m_code = -1; end
            else m_t++;
        end
    endtask

    // One clock: check registered outputs, apply inputs, check in_ready, advance.
    task automatic cycle(input logic e, input logic m, input logic v, input logic [2:0] code);
        bit rdy;
        @(negedge clk);
        check_outputs();
        en = e; mode = m; in_valid = v; a = code;
        #1;
        rdy = (m_st == 1) && e && !m;
        check("hi.in_ready", 32'(in_ready0), 32'(rdy));
        check("lo.in_ready", 32'(in_ready1), 32'(rdy));
        @(posedge clk);
        model_step();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear with no edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        en = 1'b0;
        #1;
        m_st = 0; m_t = 0; m_code = -1;
        check_outputs();
        check("rst.in_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;
        @(posedge clk);
        model_step();

        // DIRECT sweep, then hold with in_valid low.
        cycle(1, 0, 0, 3'd0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 1, 3'(k));
        repeat (3) cycle(1, 0, 0, 3'd1);

        // SCAN across two full periods of the slow instance.
        repeat (40) cycle(1, 1, 0, 3'd0);
        async_reset();

        // Scan to idx=5 on the slow instance, drop en, re-enable.
        cycle(1, 1, 0, 3'd0);
        repeat (11) cycle(1, 1, 0, 3'd0);
        cycle(0, 1, 0, 3'd0);
        repeat (6) cycle(1, 1, 0, 3'd0);

        // Leave SCAN with a simultaneous input, then a real transfer.
        cycle(1, 0, 1, 3'd3);
        cycle(1, 0, 1, 3'd3);
        cycle(1, 0, 0, 3'd0);
        cycle(1, 1, 1, 3'd6);
        cycle(1, 1, 0, 3'd0);

        // Randomized segments with occasional mid-run reset.
        for (int seg = 0; seg < 48; seg++) begin
            logic e, m;
            int   len;
            e   = ($urandom_range(0, 9) != 0);
            m   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 36);
            for (int c = 0; c < len; c++)
                cycle(e, m, 1'($urandom), 3'($urandom));
            if (seg % 16 == 9) async_reset();
        end
        cycle(1, 0, 0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
